// File: rtl/mouse_paddle_emu_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mouse_paddle_emu_if
// Purpose  : Bundles the PS/2 mouse packet, the analog stick and the mode
//            inputs together with the paddle outputs of mouse_paddle_emu.
// Ports    : ps2_mouse[24:0]  mouse packet (bit 24 toggles once per packet)
//            joya[15:0]       signed analog stick, [7:0] X, [15:8] Y
//            mode[1:0]        bit 0 spring-return, bit 1 invert Y
//            ax/ay[W-1:0]     signed paddle values
//            btn[2:0]         latched mouse buttons
//            mouse_active     mouse currently owns the axes
// Revision : 1.0  initial release
// ============================================================================
interface mouse_paddle_emu_if #(
  parameter int W = 8
);
  logic [24:0]         ps2_mouse;
  logic [15:0]         joya;
  logic [1:0]          mode;
  logic signed [W-1:0] ax;
  logic signed [W-1:0] ay;
  logic [2:0]          btn;
  logic                mouse_active;

  // master: the side that supplies mouse/stick/mode and observes the paddles
  modport master (
    output ps2_mouse, joya, mode,
    input  ax, ay, btn, mouse_active
  );

  // slave: the emulator itself
  modport slave (
    input  ps2_mouse, joya, mode,
    output ax, ay, btn, mouse_active
  );
endinterface
`default_nettype wire

// File: rtl/mouse_paddle_emu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mouse_paddle_emu
// Purpose  : Turns relative PS/2 mouse motion into absolute signed paddle
//            positions. Each packet adds a scaled, clamped delta to a
//            saturating accumulator. Any non-centred analog stick takes the
//            axes back and clears the accumulators. An optional spring
//            return walks the accumulators one step toward zero every DECAY
//            cycles.
// Ports    : clk_sys          system clock
//            reset            synchronous, active-high reset
//            bus (slave)      ps2_mouse, joya, mode in; ax, ay, btn,
//                             mouse_active out (all outputs registered)
// Revision : 1.0  initial release
// ============================================================================
module mouse_paddle_emu #(
  parameter int W     = 8,
  parameter int DMAX  = 10,
  parameter int SHIFT = 1,
  parameter int DECAY = 65536
) (
  input  logic              clk_sys,
  input  logic              reset,
  mouse_paddle_emu_if.slave bus
);

  // Accumulation is done in W+2 bits so that acc + delta can never wrap
  // before the saturation test.
  localparam int c_aw = W + 2;
  localparam int c_cw = (DECAY > 1) ? $clog2(DECAY) : 1;

  localparam logic signed [c_aw-1:0] c_dmax = c_aw'(DMAX);
  localparam logic signed [c_aw-1:0] c_dmin = -c_aw'(DMAX);
  localparam logic signed [c_aw-1:0] c_amax = c_aw'((2 ** (W - 1)) - 1);
  localparam logic signed [c_aw-1:0] c_amin = c_aw'(-(2 ** (W - 1)));
  localparam logic [c_cw-1:0]        c_tc   = c_cw'(DECAY - 1);

  // {sign, byte} -> arithmetic shift -> clamp to +/-DMAX
  function automatic logic signed [c_aw-1:0] scale_clamp(
    input logic       sign,
    input logic [7:0] mag
  );
    logic signed [8:0]      raw;
    logic signed [8:0]      scaled;
    logic signed [c_aw-1:0] ext;
    raw    = {sign, mag};
    scaled = raw >>> SHIFT;
    ext    = {{(c_aw-9){scaled[8]}}, scaled};
    if (ext > c_dmax)      return c_dmax;
    else if (ext < c_dmin) return c_dmin;
    else                   return ext;
  endfunction

  function automatic logic signed [W-1:0] sat_add(
    input logic signed [W-1:0]    acc,
    input logic signed [c_aw-1:0] delta
  );
    logic signed [c_aw-1:0] sum;
    sum = {{2{acc[W-1]}}, acc} + delta;
    if (sum > c_amax)      return c_amax[W-1:0];
    else if (sum < c_amin) return c_amin[W-1:0];
    else                   return sum[W-1:0];
  endfunction

  // One step toward zero; zero stays put so it can never overshoot.
  function automatic logic signed [W-1:0] toward_zero(
    input logic signed [W-1:0] acc
  );
    if (acc == '0)    return acc;
    else if (acc[W-1]) return acc + W'(1);
    else              return acc - W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                r_strobe;
  logic                r_active;
  logic signed [W-1:0] r_acc_x;
  logic signed [W-1:0] r_acc_y;
  logic [2:0]          r_btn;
  logic [c_cw-1:0]     r_cnt;
  logic signed [W-1:0] r_ax;
  logic signed [W-1:0] r_ay;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic                   w_packet;
  logic                   w_joy;
  logic                   w_run;
  logic                   w_tc;
  logic signed [c_aw-1:0] w_dx;
  logic signed [c_aw-1:0] w_dy_raw;
  logic signed [c_aw-1:0] w_dy;
  logic signed [W-1:0]    w_joy_x;
  logic signed [W-1:0]    w_joy_y;
  logic                   w_active_nxt;
  logic [2:0]             w_btn_nxt;
  logic signed [W-1:0]    w_acc_x_nxt;
  logic signed [W-1:0]    w_acc_y_nxt;
  logic [c_cw-1:0]        w_cnt_nxt;
  logic                   w_unused;

  assign w_packet = bus.ps2_mouse[24] ^ r_strobe;
  assign w_joy    = |bus.joya;
  assign w_run    = bus.mode[0] & r_active;
  assign w_tc     = (r_cnt == c_tc);

  assign w_dx     = scale_clamp(bus.ps2_mouse[4], bus.ps2_mouse[15:8]);
  assign w_dy_raw = scale_clamp(bus.ps2_mouse[5], bus.ps2_mouse[23:16]);
  assign w_dy     = bus.mode[1] ? -w_dy_raw : w_dy_raw;

  // Stick bytes occupy the top 8 bits of the paddle word, low bits zero.
  assign w_joy_x  = W'(signed'(bus.joya[7:0]))  <<< (W - 8);
  assign w_joy_y  = W'(signed'(bus.joya[15:8])) <<< (W - 8);

  // The counter wraps regardless of whether its step was consumed.
  assign w_cnt_nxt = w_run ? (w_tc ? '0 : r_cnt + c_cw'(1)) : '0;

  // Priority: stick override, then packet, then spring step.
  always_comb begin
    w_active_nxt = r_active;
    w_btn_nxt    = r_btn;
    w_acc_x_nxt  = r_acc_x;
    w_acc_y_nxt  = r_acc_y;
    if (w_joy) begin
      w_active_nxt = 1'b0;
      w_btn_nxt    = '0;
      w_acc_x_nxt  = '0;
      w_acc_y_nxt  = '0;
    end else if (w_packet) begin
      w_active_nxt = 1'b1;
      w_btn_nxt    = bus.ps2_mouse[2:0];
      w_acc_x_nxt  = sat_add(r_acc_x, w_dx);
      w_acc_y_nxt  = sat_add(r_acc_y, w_dy);
    end else if (w_run && w_tc) begin
      w_acc_x_nxt  = toward_zero(r_acc_x);
      w_acc_y_nxt  = toward_zero(r_acc_y);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Loading the live strobe keeps the first post-reset edge packet-free.
      r_strobe <= bus.ps2_mouse[24];
      r_active <= 1'b0;
      r_acc_x  <= '0;
      r_acc_y  <= '0;
      r_btn    <= '0;
      r_cnt    <= '0;
      r_ax     <= '0;
      r_ay     <= '0;
    end else begin
      r_strobe <= bus.ps2_mouse[24];
      r_active <= w_active_nxt;
      r_acc_x  <= w_acc_x_nxt;
      r_acc_y  <= w_acc_y_nxt;
      r_btn    <= w_btn_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ax     <= w_active_nxt ? w_acc_x_nxt : w_joy_x;
      r_ay     <= w_active_nxt ? w_acc_y_nxt : w_joy_y;
    end
  end

  assign bus.ax           = r_ax;
  assign bus.ay           = r_ay;
  assign bus.btn          = r_btn;
  assign bus.mouse_active = r_active;

  // Packet bits not used by the emulator.
  assign w_unused = &{1'b0, bus.ps2_mouse[7:6], bus.ps2_mouse[3]};

endmodule
`default_nettype wire

// File: tb/tb_mouse_paddle_emu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mouse_paddle_emu
// Purpose  : Self-checking bench for mouse_paddle_emu (W=8, DMAX=10,
//            SHIFT=1, DECAY=4). A behavioural model pushes the expected
//            outputs for every clock edge into a queue; they are popped and
//            compared 1 ns after that edge.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_mouse_paddle_emu;
  localparam int W     = 8;
  localparam int DMAX  = 10;
  localparam int SHIFT = 1;
  localparam int DECAY = 4;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  mouse_paddle_emu_if #(.W(W)) bus ();

  mouse_paddle_emu #(
    .W(W), .DMAX(DMAX), .SHIFT(SHIFT), .DECAY(DECAY)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    int ax;
    int ay;
    int btn;
    int act;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Last observed DUT outputs, for scenario-level checks.
  int last_ax, last_ay, last_btn, last_act;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit m_strobe = 1'b0;
  int m_act = 0, m_ax = 0, m_ay = 0, m_btn = 0, m_cnt = 0;

  function automatic int delta(input bit s, input bit [7:0] b);
    int r;
    r = s ? int'(b) - 256 : int'(b);
    r = r >>> SHIFT;
    if (r > DMAX)  r = DMAX;
    if (r < -DMAX) r = -DMAX;
    return r;
  endfunction

  function automatic int sat(input int v);
    if (v > (1 << (W - 1)) - 1) return (1 << (W - 1)) - 1;
    if (v < -(1 << (W - 1)))    return -(1 << (W - 1));
    return v;
  endfunction

  function automatic int tz(input int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return 0;
  endfunction

  task automatic model_step();
    exp_t e;
    bit   pkt, tc, run;
    int   ncnt, dy;
    if (reset) begin
      m_strobe = bus.ps2_mouse[24];
      m_act = 0; m_ax = 0; m_ay = 0; m_btn = 0; m_cnt = 0;
      e = '{0, 0, 0, 0};
    end else begin
      pkt      = (bus.ps2_mouse[24] != m_strobe);
      m_strobe = bus.ps2_mouse[24];
      tc       = (m_cnt == DECAY - 1);
      run      = bus.mode[0] && (m_act != 0);
      ncnt     = run ? (tc ? 0 : m_cnt + 1) : 0;
      if (bus.joya != 16'h0) begin
        m_act = 0; m_ax = 0; m_ay = 0; m_btn = 0;
      end else if (pkt) begin
        m_act = 1;
        m_btn = int'(bus.ps2_mouse[2:0]);
        dy    = delta(bus.ps2_mouse[5], bus.ps2_mouse[23:16]);
        if (bus.mode[1]) dy = -dy;
        m_ax  = sat(m_ax + delta(bus.ps2_mouse[4], bus.ps2_mouse[15:8]));
        m_ay  = sat(m_ay + dy);
      end else if (run && tc) begin
        m_ax = tz(m_ax);
        m_ay = tz(m_ay);
      end
      m_cnt = ncnt;
      if (m_act != 0) begin
        e.ax = m_ax;
        e.ay = m_ay;
      end else begin
        e.ax = int'($signed(bus.joya[7:0]))  * (1 << (W - 8));
        e.ay = int'($signed(bus.joya[15:8])) * (1 << (W - 8));
      end
      e.btn = m_btn;
      e.act = m_act;
    end
    q.push_back(e);
  endtask

  // ------------------------------------------------------------- stimulus
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk_sys);
    #1;
    e        = q.pop_front();
    last_ax  = int'(bus.ax);
    last_ay  = int'(bus.ay);
    last_btn = int'(bus.btn);
    last_act = int'(bus.mouse_active);
    check("ax",     last_ax,  e.ax);
    check("ay",     last_ay,  e.ay);
    check("btn",    last_btn, e.btn);
    check("active", last_act, e.act);
  endtask

  task automatic send_pkt(input bit [7:0] xb, input bit xs,
                          input bit [7:0] yb, input bit ys,
                          input bit [2:0] b);
    bus.ps2_mouse = {~bus.ps2_mouse[24], yb, xb, 2'b00, ys, xs, 1'b0, b};
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  int frozen, prior;

  initial begin
    bus.ps2_mouse = '0;
    bus.joya      = '0;
    bus.mode      = 2'b00;

    // Reset state
    do_reset();
    check("reset_ax",  last_ax,  0);
    check("reset_act", last_act, 0);
    cycle();

    // First packet: X 0x14 -> +10
    send_pkt(8'h14, 1'b0, 8'h00, 1'b0, 3'b000);
    check("first_ax",  last_ax,  10);
    check("first_ay",  last_ay,  0);
    check("first_act", last_act, 1);

    // Positive saturation
    do_reset();
    for (int i = 0; i < 12; i++) send_pkt(8'h60, 1'b0, 8'h00, 1'b0, 3'b000);
    check("pos_120", last_ax, 120);
    send_pkt(8'h60, 1'b0, 8'h00, 1'b0, 3'b000);
    check("pos_sat", last_ax, 127);
    send_pkt(8'h60, 1'b0, 8'h00, 1'b0, 3'b000);
    check("pos_hold", last_ax, 127);

    // Negative saturation: raw -128 -> -64 -> clamped -10
    do_reset();
    for (int i = 0; i < 14; i++) send_pkt(8'h80, 1'b1, 8'h00, 1'b0, 3'b000);
    check("neg_sat", last_ax, -128);
    send_pkt(8'h80, 1'b1, 8'h00, 1'b0, 3'b000);
    check("neg_hold", last_ax, -128);

    // Stick override beats a simultaneous packet
    do_reset();
    for (int i = 0; i < 5; i++) send_pkt(8'h14, 1'b0, 8'h00, 1'b0, 3'b111);
    check("pre_ovr_ax", last_ax, 50);
    bus.joya = 16'h0020;
    send_pkt(8'h14, 1'b0, 8'h00, 1'b0, 3'b111);
    check("ovr_ax",  last_ax,  32);
    check("ovr_ay",  last_ay,  0);
    check("ovr_act", last_act, 0);
    check("ovr_btn", last_btn, 0);
    bus.joya = 16'h8001;
    cycle();
    check("joy_ay_neg", last_ay, -128);
    bus.joya = 16'h0000;
    cycle();
    check("joy_release", last_ax, 0);

    // Spring return 3 -> 2 -> 1 -> 0
    do_reset();
    bus.mode = 2'b01;
    send_pkt(8'h06, 1'b0, 8'h00, 1'b0, 3'b000);
    check("decay_start", last_ax, 3);
    for (int k = 1; k <= 3; k++) begin
      repeat (DECAY) cycle();
      check("decay_step", last_ax, 3 - k);
    end
    repeat (2 * DECAY) cycle();
    check("decay_zero", last_ax, 0);

    // Packet on a terminal-count edge: delta applied, no decay
    send_pkt(8'h0C, 1'b0, 8'h00, 1'b0, 3'b000);
    for (int i = 0; i < 3 * DECAY && m_cnt != DECAY - 1; i++) cycle();
    prior = m_ax;
    send_pkt(8'h04, 1'b0, 8'h00, 1'b0, 3'b000);
    check("pkt_on_tc", last_ax, prior + 2);

    // Clearing spring-return freezes the accumulators
    bus.mode = 2'b00;
    cycle();
    frozen = m_ax;
    repeat (3 * DECAY) cycle();
    check("freeze", last_ax, frozen);

    // Y inversion and buttons
    do_reset();
    bus.mode = 2'b10;
    send_pkt(8'h00, 1'b0, 8'h08, 1'b0, 3'b101);
    check("inv_ay",  last_ay,  -4);
    check("btn_101", last_btn, 5);
    bus.mode = 2'b00;
    cycle();
    check("inv_keep", last_ay, -4);
    send_pkt(8'h00, 1'b0, 8'h08, 1'b0, 3'b010);
    check("inv_off", last_ay, 0);

    // Strobe toggled during reset must not produce a packet
    reset = 1'b1;
    cycle();
    bus.ps2_mouse[24] = ~bus.ps2_mouse[24];
    cycle();
    reset = 1'b0;
    cycle();
    check("no_spurious", last_act, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45) begin
        bus.ps2_mouse = {~bus.ps2_mouse[24], 8'($urandom), 8'($urandom),
                         2'b00, 1'($urandom), 1'($urandom), 1'b0, 3'($urandom)};
      end
      bus.joya = (r >= 96) ? 16'($urandom_range(1, 65535)) : 16'h0000;
      if (r >= 90 && r < 94) bus.mode = 2'($urandom);
      reset = (r == 89);
      cycle();
    end
    reset = 1'b0;
    bus.joya = '0;
    cycle();

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mouse_paddle_emu.md
MOUSE_PADDLE_EMU -- requirements
Module: mouse_paddle_emu

Parameters
REQ-001 SHALL provide parameter W, default 8: paddle output width in bits, signed, legal range 8..12.
REQ-002 SHALL provide parameter DMAX, default 10: per-packet delta magnitude limit, legal range 1..2^(W-1)-1.
REQ-003 SHALL provide parameter SHIFT, default 1: arithmetic right shift applied to raw mouse delta (sensitivity), legal range 0..4.
REQ-004 SHALL provide parameter DECAY, default 65536: spring-return step period in clk_sys cycles, minimum 2.

Interface
REQ-005 clk_sys  in  1  system clock; the only clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ps2_mouse  in  25  bit 24 packet toggle strobe; [23:16] Y byte; [15:8] X byte; bit 5 Y sign; bit 4 X sign; [2:0] buttons.
REQ-008 joya  in  16  analog stick, signed: [7:0] X, [15:8] Y.
REQ-009 mode  in  2  bit 0 spring-return enable; bit 1 invert Y.
REQ-010 ax  out  W  signed X paddle value, registered.
REQ-011 ay  out  W  signed Y paddle value, registered.
REQ-012 btn  out  3  mouse buttons, registered.
REQ-013 mouse_active  out  1  high while mouse owns the axes.

Function
REQ-014 A packet SHALL be detected on a clock edge where ps2_mouse[24] differs from its registered copy; the copy updates every cycle.
REQ-015 Raw delta SHALL be 9-bit two's complement {sign, byte} per axis; scaled = raw >>> SHIFT; clamped = limit(scaled, -DMAX, +DMAX).
REQ-016 With mode[1]=1, the clamped Y delta SHALL be negated before accumulation; X is never inverted.
REQ-017 On a packet, each accumulator SHALL compute acc + clamped in W+2 bits and saturate to [-2^(W-1), 2^(W-1)-1]; no wrap-around.
REQ-018 On a packet, mouse_active SHALL be set to 1 and btn SHALL latch ps2_mouse[2:0]; ax/ay reflect the new values after that same edge (latency 1 cycle from strobe change).
REQ-019 Any edge with joya != 0 SHALL clear mouse_active, both accumulators and btn; this override takes priority over a simultaneous packet, which is discarded.
REQ-020 While mouse_active=0, ax/ay SHALL output joya X/Y bytes sign-extended into the top 8 bits of W, low W-8 bits zero, registered with 1-cycle latency.
REQ-021 While mouse_active=1, ax/ay SHALL output the accumulators.
REQ-022 Spring-return: a decay counter SHALL count 0..DECAY-1 and wrap, running only while mode[0]=1 and mouse_active=1, otherwise held at 0.
REQ-023 At counter terminal count, each nonzero accumulator SHALL move 1 toward zero; a zero accumulator stays zero; never overshoots.
REQ-024 If a packet and a decay step coincide, the packet update SHALL win for that edge and the decay step is dropped; the counter still wraps.
REQ-025 Clearing mode[0] mid-operation SHALL freeze accumulators at their current values and zero the counter.
REQ-026 A mode[1] change SHALL affect only subsequent packets, not existing accumulator values.

Reset
REQ-027 Reset SHALL clear ax, ay, btn, mouse_active, both accumulators and the decay counter to 0.
REQ-028 During reset, the strobe copy SHALL load ps2_mouse[24], so no packet is detected on the first post-reset cycle.
REQ-029 Reset asserted mid-packet or mid-decay SHALL take priority over all other updates on that edge.

Verification (W=8, DMAX=10, SHIFT=1, DECAY=4 unless stated)
REQ-030 Reset, joya=0, toggle strobe with X byte 0x14, sign 0 -> next edge ax=10, ay=0, mouse_active=1.
REQ-031 Thirteen packets with X byte 0x60, sign 0 -> ax steps by 10 to 120, then saturates at 127; further packets hold 127.
REQ-032 Fourteen packets with X byte 0x80, sign 1 (raw -128, clamped -10) from 0 -> ax=-128, held at -128 on further packets.
REQ-033 Active with ax=50; joya=0x0020 applied on the same edge as a packet -> mouse_active=0, packet discarded, ax=0x20, ay=0x00, btn=0.
REQ-034 mode=01, ax=3, no packets -> ax decays 3->2->1->0 at 4-cycle intervals and stays 0; a packet arriving on a terminal-count edge applies its delta with no decay on that edge.
REQ-035 mode=10, Y byte 0x08, sign 0 -> ay=-4; ps2_mouse[2:0]=101 -> btn=101; reset with strobe already toggled -> no spurious packet on release.
